// File: rtl/regfile_writeback_queue_if.sv
// Writeback bus for regfile_writeback_queue: two producer handshakes, the bank
// write port, two bypass lookups and the occupancy count.
interface regfile_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int PEND_W = $clog2(DEPTH + 1);

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              rf_hold;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_write_register;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] byp_reg1;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic [ADDR_W-1:0] byp_reg2;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;
    logic [PEND_W-1:0] pending;

    modport master (
        output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
               rf_hold, byp_reg1, byp_reg2,
        input  mem_ready, alu_ready, rf_write, rf_write_register, rf_write_data,
               byp_hit1, byp_data1, byp_hit2, byp_data2, pending
    );

    modport slave (
        input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
               rf_hold, byp_reg1, byp_reg2,
        output mem_ready, alu_ready, rf_write, rf_write_register, rf_write_data,
               byp_hit1, byp_data1, byp_hit2, byp_data2, pending
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO in front of the register bank's single write port,
// with youngest-first bypass lookups. Optional macro: ZERO_REG_DISCARD_EN.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic clk,
    input  logic rst,
    regfile_writeback_queue_if.slave wb
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PEND_W = $clog2(DEPTH + 1);
    localparam logic [PEND_W-1:0] DEPTH_M1 = PEND_W'(DEPTH - 1);
    localparam logic [PEND_W-1:0] DEPTH_M2 = PEND_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] ZR_IDX   = ADDR_W'(31);
`ifdef ZERO_REG_DISCARD_EN
    localparam bit ZR_DISCARD = 1'b1;
`else
    localparam bit ZR_DISCARD = 1'b0;
`endif

    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  head, tail, alu_slot;
    logic [PEND_W-1:0] pending_q;
    logic              mem_store, alu_store, pop;
    logic [1:0]        n_store;
    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_reg_p1;
    logic [DATA_W-1:0] wr_data_p1;
    logic [DATA_W:0]   byp1, byp2;

    // Credit comes only from registered occupancy; a same-cycle pop frees nothing.
    always_comb begin
        wb.mem_ready = (pending_q <= DEPTH_M1);
        wb.alu_ready = (pending_q <= DEPTH_M2) | ((pending_q == DEPTH_M1) & ~wb.mem_valid);
        mem_store    = wb.mem_valid & wb.mem_ready & ~(ZR_DISCARD & (wb.mem_rd == ZR_IDX));
        alu_store    = wb.alu_valid & wb.alu_ready & ~(ZR_DISCARD & (wb.alu_rd == ZR_IDX));
        n_store      = {1'b0, mem_store} + {1'b0, alu_store};
        alu_slot     = mem_store ? tail + PTR_W'(1) : tail;
        pop          = (pending_q != '0) & ~wb.rf_hold;
    end

    // Enqueue stage: mem entry takes the older slot when both arrive together.
    always_ff @(posedge clk) begin
        if (mem_store) begin
            q_rd[tail]   <= wb.mem_rd;
            q_data[tail] <= wb.mem_data;
        end
        if (alu_store) begin
            q_rd[alu_slot]   <= wb.alu_rd;
            q_data[alu_slot] <= wb.alu_data;
        end
    end

    // Drain stage: head entry moves into the bank write register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            pending_q  <= '0;
            wr_vld_p1  <= 1'b0;
            wr_reg_p1  <= '0;
            wr_data_p1 <= '0;
        end else begin
            tail      <= tail + PTR_W'(n_store);
            pending_q <= pending_q + PEND_W'(n_store) - PEND_W'(pop);
            wr_vld_p1 <= pop;
            if (pop) begin
                head       <= head + PTR_W'(1);
                wr_reg_p1  <= q_rd[head];
                wr_data_p1 <= q_data[head];
            end
        end
    end

    // Oldest to youngest, so the last match (youngest) wins; output register is oldest.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
        logic              hit;
        logic [DATA_W-1:0] d;
        logic [PTR_W-1:0]  idx;
        hit = 1'b0;
        d   = '0;
        if (wr_vld_p1 && (wr_reg_p1 == r)) begin
            hit = 1'b1;
            d   = wr_data_p1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((PEND_W'(k) < pending_q) && (q_rd[idx] == r)) begin
                hit = 1'b1;
                d   = q_data[idx];
            end
        end
        if (ZR_DISCARD && (r == ZR_IDX)) begin
            hit = 1'b0;
            d   = '0;
        end
        return {hit, d};
    endfunction

    always_comb begin
        byp1 = lookup(wb.byp_reg1);
        byp2 = lookup(wb.byp_reg2);
    end

    assign wb.byp_hit1          = byp1[DATA_W];
    assign wb.byp_data1         = byp1[DATA_W-1:0];
    assign wb.byp_hit2          = byp2[DATA_W];
    assign wb.byp_data2         = byp2[DATA_W-1:0];
    assign wb.rf_write          = wr_vld_p1;
    assign wb.rf_write_register = wr_reg_p1;
    assign wb.rf_write_data     = wr_data_p1;
    assign wb.pending           = pending_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed-vector bench for regfile_writeback_queue with a small register-bank model.
module tb_regfile_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [DATA_W-1:0] bank [32];

    regfile_writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (wb.rf_write) bank[wb.rf_write_register] <= wb.rf_write_data;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0;
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
        idle_inputs();
        wb.rf_hold  = 1'b0;
        wb.byp_reg1 = '0;
        wb.byp_reg2 = '0;

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("rst_rf_write", 64'(wb.rf_write), 64'd0);
        check("rst_pending", 64'(wb.pending), 64'd0);
        check("rst_byp_hit1", 64'(wb.byp_hit1), 64'd0);
        check("rst_wdata", wb.rf_write_data, 64'd0);
        check("rst_mem_ready", 64'(wb.mem_ready), 64'd1);
        check("rst_alu_ready", 64'(wb.alu_ready), 64'd1);
        #1 rst = 1'b0;
        tick();

        // Single ALU write
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 64'hAA;
        wb.byp_reg1 = 5'd3;
        #1;
        check("single_byp_pre", 64'(wb.byp_hit1), 64'd0);
        tick();
        idle_inputs();
        #1;
        check("single_pending", 64'(wb.pending), 64'd1);
        check("single_wr_early", 64'(wb.rf_write), 64'd0);
        check("single_byp_hit_q", 64'(wb.byp_hit1), 64'd1);
        check("single_byp_data_q", wb.byp_data1, 64'hAA);
        tick();
        check("single_wr", 64'(wb.rf_write), 64'd1);
        check("single_wreg", 64'(wb.rf_write_register), 64'd3);
        check("single_wdata", wb.rf_write_data, 64'hAA);
        check("single_byp_out", wb.byp_data1, 64'hAA);
        check("single_pend0", 64'(wb.pending), 64'd0);
        tick();
        check("single_bank", bank[3], 64'hAA);
        check("single_wr_off", 64'(wb.rf_write), 64'd0);
        check("single_byp_miss", 64'(wb.byp_hit1), 64'd0);
        check("single_byp_zero", wb.byp_data1, 64'd0);

        // Dual enqueue to the same register
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd5; wb.mem_data = 64'h11;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 64'h22;
        wb.byp_reg1 = 5'd5;
        #1;
        check("dual_mem_ready", 64'(wb.mem_ready), 64'd1);
        check("dual_alu_ready", 64'(wb.alu_ready), 64'd1);
        tick();
        idle_inputs();
        #1;
        check("dual_pending", 64'(wb.pending), 64'd2);
        check("dual_byp_both", wb.byp_data1, 64'h22);
        tick();
        check("dual_first", wb.rf_write_data, 64'h11);
        check("dual_pend1", 64'(wb.pending), 64'd1);
        check("dual_byp_after", wb.byp_data1, 64'h22);
        tick();
        check("dual_second", wb.rf_write_data, 64'h22);
        check("dual_second_wr", 64'(wb.rf_write), 64'd1);
        check("dual_byp_out", wb.byp_data1, 64'h22);
        tick();
        check("dual_bank", bank[5], 64'h22);
        check("dual_idle", 64'(wb.rf_write), 64'd0);

        // Fill under hold
        wb.rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = ADDR_W'(10 + i); wb.alu_data = 64'(256 + i);
            tick();
        end
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd9; wb.mem_data = 64'h999;
        #1;
        check("fill_p3", 64'(wb.pending), 64'd3);
        check("fill_p3_mem_rdy", 64'(wb.mem_ready), 64'd1);
        check("fill_p3_alu_rdy", 64'(wb.alu_ready), 64'd0);
        wb.mem_valid = 1'b0;
        wb.alu_rd = 5'd13; wb.alu_data = 64'd259;
        #1;
        check("fill_p3_alu_solo", 64'(wb.alu_ready), 64'd1);
        tick();
        idle_inputs();
        #1;
        check("full_pending", 64'(wb.pending), 64'd4);
        check("full_mem_rdy", 64'(wb.mem_ready), 64'd0);
        check("full_alu_rdy", 64'(wb.alu_ready), 64'd0);
        check("full_hold_wr", 64'(wb.rf_write), 64'd0);
        wb.rf_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_wr", 64'(wb.rf_write), 64'd1);
            check("drain_reg", 64'(wb.rf_write_register), 64'(10 + i));
            check("drain_data", wb.rf_write_data, 64'(256 + i));
        end
        tick();
        check("drain_done", 64'(wb.rf_write), 64'd0);
        check("drain_pend", 64'(wb.pending), 64'd0);

        // Reset with entries in flight
        wb.rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = ADDR_W'(20 + i); wb.alu_data = 64'(4096 + i);
            tick();
        end
        idle_inputs();
        wb.byp_reg1 = 5'd20; wb.byp_reg2 = 5'd21;
        #1;
        check("mid_pending", 64'(wb.pending), 64'd3);
        check("mid_byp_pre", wb.byp_data2, 64'd4097);
        rst = 1'b1;
        #1;
        check("mid_rst_pend", 64'(wb.pending), 64'd0);
        check("mid_rst_byp1", 64'(wb.byp_hit1), 64'd0);
        check("mid_rst_byp2", 64'(wb.byp_hit2), 64'd0);
        #1 rst = 1'b0;
        wb.rf_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_write", 64'(wb.rf_write), 64'd0);
        end
        check("mid_bank20", bank[20], 64'd0);

        // Register 31 handling
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd31; wb.alu_data = 64'h55;
        wb.byp_reg2 = 5'd31;
        #1;
        check("r31_ready", 64'(wb.alu_ready), 64'd1);
        tick();
        idle_inputs();
        #1;
`ifdef ZERO_REG_DISCARD_EN
        check("r31_pending", 64'(wb.pending), 64'd0);
        check("r31_byp_hit", 64'(wb.byp_hit2), 64'd0);
        tick();
        check("r31_wr", 64'(wb.rf_write), 64'd0);
`else
        check("r31_pending", 64'(wb.pending), 64'd1);
        check("r31_byp_hit", 64'(wb.byp_hit2), 64'd1);
        check("r31_byp_data", wb.byp_data2, 64'h55);
        tick();
        check("r31_wr", 64'(wb.rf_write), 64'd1);
        check("r31_reg", 64'(wb.rf_write_register), 64'd31);
        check("r31_data", wb.rf_write_data, 64'h55);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
